diffeq_solver: RTL and testbench
================================

Name: diffeq_solver

Overview:
- Parametrised successor of the fixed 8-bit Project1 differential-equation solver.
- Iterates the forward-Euler loop "while (x < a) { x += dx; u -= 3*x*u*dx + 3*y*dx; y += u*dx; }" on signed WIDTH-bit operands.
- dx and a are runtime inputs. One multiplier is shared across the iteration.
- Adds a start/busy/done handshake, an iteration counter and an iteration-limit timeout.

Parameters:
- WIDTH, 16, data width of x/u/y/dx/a, signed two's complement.
- ITER_W, 8, width of the iteration counter.
- MAX_ITER, 255, iteration limit; must be less than 2**ITER_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  WIDTH  initial x.
- u_in  in  WIDTH  initial u.
- y_in  in  WIDTH  initial y.
- dx_in  in  WIDTH  step size.
- a_in  in  WIDTH  loop bound.
- x_out  out  WIDTH  final x, registered.
- u_out  out  WIDTH  final u, registered.
- y_out  out  WIDTH  final y, registered.
- iter_out  out  ITER_W  iterations executed in the last run.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse when results are valid.
- timeout  out  1  last run stopped on MAX_ITER with x < a.

Behaviour:
- Reset (rst=1 at an edge): all outputs, working registers and counters go to 0; state goes to IDLE. Reset overrides everything, including mid-run; an aborted run produces no done.
- Working registers: x, u, y, dx, a, p1, p2, iter.
- States: IDLE, CHECK, MUL1, MUL2, MUL3, UPDATE.
- IDLE:
  - If start=1: load x/u/y/dx/a from the inputs, clear iter, set busy=1, go to CHECK.
  - Otherwise stay. done=0 in IDLE except for the pulse cycle.
- CHECK:
  - Exit if signed x >= a, or if iter == MAX_ITER.
  - On exit: latch x/u/y/iter into the outputs, set timeout = (x < a), pulse done=1 for one cycle, clear busy, go to IDLE.
  - Otherwise go to MUL1.
- MUL1: p1 <= u*dx.
- MUL2: p2 <= (3x)*p1. Compute 3x as (x<<1)+x, no second multiplier.
- MUL3: p3 = (3y)*dx, used combinationally in UPDATE or registered here; either is acceptable if the latency is met.
- UPDATE:
  - x <= x+dx; u <= u-p2-p3; y <= y+p1.
  - All three updates use pre-update values.
  - iter <= iter+1; go to CHECK.
- Arithmetic: every product and sum is truncated to the low WIDTH bits (modular wrap, no saturation). Comparisons are signed.
- Latency: counting the start-accepting edge as edge 0, done is asserted after edge 5N+1, where N is the iteration count. N=0 gives done one cycle after acceptance.
- Output holding: x/u/y/iter/timeout outputs hold until the next done. They do not change while busy.
- start while busy is ignored, with no queuing.
- start high in the done cycle: the FSM is already in IDLE, so it is accepted at the next edge. Back-to-back runs are legal.
- Inputs are sampled only at the accepting edge; later input changes do not affect a run in progress.
- Boundary cases:
  - dx=0 with x<a never converges and terminates via MAX_ITER with timeout=1.
  - MAX_ITER=0 always exits at the first CHECK: timeout=1 if x<a, else 0.
  - x == a at start exits immediately with iter=0 and timeout=0.

Test Plan:
- Nominal run:
  - Stimulus (WIDTH=16): x=2, u=4, y=4, dx=1, a=4, start pulse.
  - Response: done after edge 11 with x_out=4, u_out=232, y_out=0xFFE8 (-24), iter_out=2, timeout=0. busy is high for exactly 11 cycles.
- Zero iterations:
  - Stimulus: x=5, u=7, y=9, dx=1, a=4.
  - Response: done after edge 1 with outputs 5/7/9, iter_out=0, timeout=0.
- Timeout:
  - Stimulus: MAX_ITER=3, x=0, u=0, y=0, dx=0, a=1.
  - Response: done after edge 16 with iter_out=3, timeout=1, x_out=0.
- Busy lockout:
  - Stimulus: during the nominal run, pulse start with different inputs and toggle x_in mid-run.
  - Response: results are identical to the nominal run and only one done pulse occurs.
  - Then assert start in the done cycle: a second run is accepted next edge and completes correctly.
- Reset mid-run:
  - Stimulus: assert rst for one cycle at edge 6 of a run.
  - Response: all outputs 0, busy=0, no done. A fresh start afterwards reproduces the nominal results.
- Wrap and sign:
  - Stimulus: x=-3, a=-1, dx=1, u=0x7FFF, y=0.
  - Response: 2 iterations, with the signed compare honoured. Checked against a bit-accurate reference model truncating to 16 bits.

Source files
------------

// File: rtl/diffeq_solver.sv
// diffeq_solver: iterative forward-Euler solver with one shared multiplier.
// Runs "while (x < a) { x += dx; u -= 3xu*dx + 3y*dx; y += u*dx; }".
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               run request, sampled only while idle
//   x_in,u_in,y_in      initial state values (signed WIDTH bits)
//   dx_in, a_in         step size and loop bound (signed WIDTH bits)
//   x_out,u_out,y_out   registered results of the last completed run
//   iter_out            iterations executed in the last completed run
//   busy                high from the accepting edge until done
//   done                one-cycle pulse when results are valid
//   timeout             last run hit MAX_ITER while x < a
module diffeq_solver #(
    parameter int WIDTH    = 16,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  u_in,
    input  logic [WIDTH-1:0]  y_in,
    input  logic [WIDTH-1:0]  dx_in,
    input  logic [WIDTH-1:0]  a_in,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  u_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [ITER_W-1:0] iter_out,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_UPDATE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_u;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_dx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_p1;
    logic [WIDTH-1:0]  r_p2;
    logic [WIDTH-1:0]  r_p3;
    logic [ITER_W-1:0] r_iter;

    logic [WIDTH-1:0]  r_x_out;
    logic [WIDTH-1:0]  r_u_out;
    logic [WIDTH-1:0]  r_y_out;
    logic [ITER_W-1:0] r_iter_out;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic              w_load;
    logic              w_exit;
    logic              w_lt;
    logic              w_stop;
    logic [WIDTH-1:0]  w_x3;
    logic [WIDTH-1:0]  w_y3;
    logic [WIDTH-1:0]  w_mul_a;
    logic [WIDTH-1:0]  w_mul_b;
    logic [WIDTH-1:0]  w_prod;

    // Triples by shift-and-add so the single multiplier stays the only one.
    assign w_x3 = (r_x << 1) + r_x;
    assign w_y3 = (r_y << 1) + r_y;

    assign w_lt   = $signed(r_x) < $signed(r_a);
    assign w_stop = !w_lt || (r_iter == MAX_C);

    // Low WIDTH bits of the product are identical for signed and unsigned.
    assign w_prod = w_mul_a * w_mul_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_exit  = 1'b0;
        w_mul_a = '0;
        w_mul_b = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_stop) begin
                    w_exit = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_MUL1;
                end
            end
            S_MUL1: begin
                w_mul_a = r_u;
                w_mul_b = r_dx;
                w_next  = S_MUL2;
            end
            S_MUL2: begin
                w_mul_a = w_x3;
                w_mul_b = r_p1;
                w_next  = S_MUL3;
            end
            S_MUL3: begin
                w_mul_a = w_y3;
                w_mul_b = r_dx;
                w_next  = S_UPDATE;
            end
            S_UPDATE: begin
                w_next = S_CHECK;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_u        <= '0;
            r_y        <= '0;
            r_dx       <= '0;
            r_a        <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_p3       <= '0;
            r_iter     <= '0;
            r_x_out    <= '0;
            r_u_out    <= '0;
            r_y_out    <= '0;
            r_iter_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_x    <= x_in;
                r_u    <= u_in;
                r_y    <= y_in;
                r_dx   <= dx_in;
                r_a    <= a_in;
                r_iter <= '0;
                r_busy <= 1'b1;
            end
            if (w_exit) begin
                r_x_out    <= r_x;
                r_u_out    <= r_u;
                r_y_out    <= r_y;
                r_iter_out <= r_iter;
                r_timeout  <= w_lt;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
            end
            case (r_state)
                S_MUL1: r_p1 <= w_prod;
                S_MUL2: r_p2 <= w_prod;
                S_MUL3: r_p3 <= w_prod;
                S_UPDATE: begin
                    // All three use pre-update values of x, u and y.
                    r_x    <= r_x + r_dx;
                    r_u    <= r_u - r_p2 - r_p3;
                    r_y    <= r_y + r_p1;
                    r_iter <= r_iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign x_out    = r_x_out;
    assign u_out    = r_u_out;
    assign y_out    = r_y_out;
    assign iter_out = r_iter_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_diffeq_solver.sv
// tb_diffeq_solver: directed vector bench for diffeq_solver.
// Main instance uses defaults; a second instance runs with MAX_ITER=3.
module tb_diffeq_solver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] u_in = '0;
    logic [15:0] y_in = '0;
    logic [15:0] dx_in = '0;
    logic [15:0] a_in = '0;

    logic [15:0] x1, u1, y1, x2, u2, y2;
    logic [7:0]  it1, it2;
    logic        busy1, done1, to1, busy2, done2, to2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    diffeq_solver u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .x_in(x_in), .u_in(u_in), .y_in(y_in),
        .dx_in(dx_in), .a_in(a_in),
        .x_out(x1), .u_out(u1), .y_out(y1),
        .iter_out(it1), .busy(busy1), .done(done1),
        .timeout(to1)
    );

    diffeq_solver #(.WIDTH(16), .ITER_W(8), .MAX_ITER(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .x_in(x_in), .u_in(u_in), .y_in(y_in),
        .dx_in(dx_in), .a_in(a_in),
        .x_out(x2), .u_out(u2), .y_out(y2),
        .iter_out(it2), .busy(busy2), .done(done2),
        .timeout(to2)
    );

    typedef struct {
        bit          sel;
        logic [15:0] x, u, y, dx, a;
        logic [15:0] ex, eu, ey;
        int          eit;
        bit          eto;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit o_busy(input bit sel);
        return sel ? busy2 : busy1;
    endfunction

    function automatic bit o_done(input bit sel);
        return sel ? done2 : done1;
    endfunction

    task automatic set_in(input vec_t v);
        x_in  = v.x;
        u_in  = v.u;
        y_in  = v.y;
        dx_in = v.dx;
        a_in  = v.a;
    endtask

    // Drives start across one edge (edge 0) and releases it.
    task automatic launch(input vec_t v);
        @(negedge clk);
        set_in(v);
        if (v.sel) start2 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat,
                             output int bcnt);
        lat = 0;
        bcnt = o_busy(sel) ? 1 : 0;
        while (lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_done(sel)) break;
            if (o_busy(sel)) bcnt++;
        end
        if (!o_done(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", lat);
        end
    endtask

    task automatic chk_res(input string tag, input vec_t v);
        logic [15:0] ax, au, ay;
        logic [7:0]  ait;
        bit          ato;
        ax  = v.sel ? x2 : x1;
        au  = v.sel ? u2 : u1;
        ay  = v.sel ? y2 : y1;
        ait = v.sel ? it2 : it1;
        ato = v.sel ? to2 : to1;
        chk({tag, ".x"}, 32'(ax), 32'(v.ex));
        chk({tag, ".u"}, 32'(au), 32'(v.eu));
        chk({tag, ".y"}, 32'(ay), 32'(v.ey));
        chk({tag, ".iter"}, 32'(ait), 32'(v.eit));
        chk({tag, ".timeout"}, 32'(ato), 32'(v.eto));
    endtask

    // Straight behavioural loop, 16-bit modular arithmetic.
    task automatic model(input vec_t v, input int maxit,
                         output vec_t r);
        logic [15:0] x, u, y, p1, p2, p3, t;
        int n;
        x = v.x; u = v.u; y = v.y; n = 0;
        while ($signed(x) < $signed(v.a) && n < maxit) begin
            p1 = u * v.dx;
            t  = x * 16'd3;
            p2 = t * p1;
            t  = y * 16'd3;
            p3 = t * v.dx;
            x  = x + v.dx;
            u  = u - p2 - p3;
            y  = y + p1;
            n++;
        end
        r = v;
        r.ex = x; r.eu = u; r.ey = y; r.eit = n;
        r.eto = $signed(x) < $signed(v.a);
    endtask

    initial begin
        int   lat, bcnt, dn;
        vec_t v, m;

        vecs[0] = '{0, 16'd2, 16'd4, 16'd4, 16'd1, 16'd4,
                    16'd4, 16'd232, 16'hFFE8, 2, 0};
        vecs[1] = '{0, 16'd5, 16'd7, 16'd9, 16'd1, 16'd4,
                    16'd5, 16'd7, 16'd9, 0, 0};
        vecs[2] = '{0, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4,
                    16'd4, 16'd1, 16'd2, 0, 0};
        vecs[3] = '{0, 16'hFFFD, 16'h7FFF, 16'd0, 16'd1, 16'hFFFF,
                    16'hFFFF, 16'h7FBD, 16'h7FF5, 2, 0};
        vecs[4] = '{0, 16'd0, 16'd1, 16'd0, 16'd2, 16'd1,
                    16'd2, 16'd1, 16'd2, 1, 0};
        vecs[5] = '{1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1,
                    16'd0, 16'd0, 16'd0, 3, 1};
        vecs[6] = '{0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1,
                    16'd0, 16'd0, 16'd0, 255, 1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.x", 32'(x1), 32'd0);
        chk("rst.iter", 32'(it1), 32'd0);
        chk("rst.busy", 32'(busy1), 32'd0);
        chk("rst.done", 32'(done1), 32'd0);
        chk("rst.timeout", 32'(to1), 32'd0);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i]);
            chk($sformatf("v%0d.busy0", i), 32'(o_busy(vecs[i].sel)), 32'd1);
            wait_done(vecs[i].sel, lat, bcnt);
            chk($sformatf("v%0d.lat", i), 32'(lat), 32'(5 * vecs[i].eit + 1));
            chk($sformatf("v%0d.busyn", i), 32'(bcnt), 32'(5 * vecs[i].eit + 1));
            chk($sformatf("v%0d.busy_at_done", i), 32'(o_busy(vecs[i].sel)), 32'd0);
            chk_res($sformatf("v%0d", i), vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.pulse", i), 32'(o_done(vecs[i].sel)), 32'd0);
        end

        v = vecs[3];
        model(v, 255, m);
        launch(v);
        wait_done(0, lat, bcnt);
        chk_res("wrap_model", m);

        v = vecs[0];
        v.sel = 1;
        launch(v);
        wait_done(1, lat, bcnt);
        chk_res("dut2_nominal", v);

        // Busy lockout: foreign start and input churn mid-run.
        launch(vecs[0]);
        lat = 0;
        dn = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) begin
                set_in(vecs[4]);
                start1 = 1'b1;
            end
            if (lat == 4) start1 = 1'b0;
            if (lat == 7) x_in = 16'd100;
            if (done1) begin
                dn++;
                break;
            end
        end
        chk("lock.lat", 32'(lat), 32'd11);
        chk("lock.dones", 32'(dn), 32'd1);
        chk_res("lock", vecs[0]);
        set_in(vecs[1]);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("b2b.busy", 32'(busy1), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.done", 32'(done1), 32'd1);
        chk_res("b2b", vecs[1]);

        // Reset at edge 6 of a nominal run.
        launch(vecs[0]);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst.x", 32'(x1), 32'd0);
        chk("mrst.u", 32'(u1), 32'd0);
        chk("mrst.y", 32'(y1), 32'd0);
        chk("mrst.iter", 32'(it1), 32'd0);
        chk("mrst.busy", 32'(busy1), 32'd0);
        chk("mrst.timeout", 32'(to1), 32'd0);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) dn++;
        end
        chk("mrst.quiet", 32'(dn), 32'd0);
        launch(vecs[0]);
        wait_done(0, lat, bcnt);
        chk("mrst.lat", 32'(lat), 32'd11);
        chk_res("mrst.rerun", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
